// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences each instruction over 3-5 cycles
// and drives datapath selects and write strobes from the opcode held in the IR.
module multicycle_control_fsm #(
  parameter bit SUPPORT_UPPER   = 1'b1,
  parameter bit SUPPORT_JALR    = 1'b1,
  parameter bit MEM_HANDSHAKE   = 1'b0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output logic       PCUpdate_o,
  output logic       Branch_o,
  output logic       RegWrite_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       AdrSrc_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ImmSrc_o,
  output logic [1:0] ALUOp_o,
  output logic       mem_req_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalrAdr  = 4'd11,
    StExecU    = 4'd12,
    StTrap     = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   ready;
  logic   dec_illegal;

  assign ready = !MEM_HANDSHAKE || mem_ready_i;

  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    // Sticky in trap mode; otherwise a one-cycle pulse after the offending decode.
    illegal_d   = TRAP_ON_ILLEGAL ? illegal_q : 1'b0;
    unique case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode: begin
        unique case (op_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBr:            state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          if (SUPPORT_JALR) state_d = StJalrAdr; else dec_illegal = 1'b1;
          OpLui, OpAuipc:  if (SUPPORT_UPPER) state_d = StExecU; else dec_illegal = 1'b1;
          default:         dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
          state_d   = TRAP_ON_ILLEGAL ? StTrap : StFetch;
          illegal_d = 1'b1;
        end
      end
      StMemAdr:   state_d = op_i[5] ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWrite: if (ready) state_d = StFetch;
      StMemWb, StBranch, StAluWb: state_d = StFetch;
      StExecR, StExecI, StExecU, StJal: state_d = StAluWb;
      StJalrAdr:  state_d = StJal;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    logic pc_upd, br, rw, mw, irw, req;
    pc_upd      = 1'b0;
    br          = 1'b0;
    rw          = 1'b0;
    mw          = 1'b0;
    irw         = 1'b0;
    req         = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    ALUOp_o     = 2'b00;
    unique case (state_q)
      StFetch: begin
        irw         = ready;
        pc_upd      = ready;
        req         = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
      end
      StDecode: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
      end
      StMemAdr, StJalrAdr: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
      end
      StMemRead: begin
        AdrSrc_o = 1'b1;
        req      = 1'b1;
      end
      StMemWb: begin
        ResultSrc_o = 2'b01;
        rw          = 1'b1;
      end
      StMemWrite: begin
        AdrSrc_o = 1'b1;
        mw       = 1'b1;
        req      = 1'b1;
      end
      StExecR: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b10;
      end
      StExecI: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b10;
      end
      StAluWb:  rw = 1'b1;
      StBranch: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b01;
        br        = 1'b1;
      end
      StJal: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        pc_upd    = 1'b1;
      end
      // lui adds the immediate to zero, auipc to OldPC.
      StExecU: begin
        ALUSrcA_o = op_i[5] ? 2'b11 : 2'b01;
        ALUSrcB_o = 2'b01;
      end
      default: ;
    endcase
    PCUpdate_o = pc_upd & ~rst_i;
    Branch_o   = br & ~rst_i;
    RegWrite_o = rw & ~rst_i;
    MemWrite_o = mw & ~rst_i;
    IRWrite_o  = irw & ~rst_i;
    mem_req_o  = req & ~rst_i;
  end

  always_comb begin
    unique case (op_i)
      OpStore:        ImmSrc_o = 3'b001;
      OpBr:           ImmSrc_o = 3'b010;
      OpJal:          ImmSrc_o = 3'b011;
      OpLui, OpAuipc: ImmSrc_o = 3'b100;
      default:        ImmSrc_o = 3'b000;
    endcase
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle RV32I core, the successor to the single-cycle main decoder.
- Moore FSM that sequences each instruction over 3-5 cycles, driving the datapath mux selects and write strobes from the opcode held in the instruction register.
- Adds lui/auipc/jalr, an optional memory-ready handshake and an illegal-opcode trap.
- Sits beside the ALU decoder; ALUOp_o feeds it unchanged.

Parameters:
- SUPPORT_UPPER, 1: 1 enables lui/auipc; 0 makes opcodes 0110111/0010111 illegal.
- SUPPORT_JALR, 1: 1 enables jalr; 0 makes opcode 1100111 illegal.
- MEM_HANDSHAKE, 0: 1 makes FETCH/MEMREAD/MEMWRITE wait for mem_ready_i; 0 ignores mem_ready_i.
- TRAP_ON_ILLEGAL, 1: 1 sends an illegal opcode to TRAP; 0 sends it back to FETCH as a nop.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- op_i  in  7  opcode field of the instruction register
- mem_ready_i  in  1  memory access completes this cycle
- PCUpdate_o  out  1  PC register write enable
- Branch_o  out  1  conditional branch evaluate
- RegWrite_o  out  1  register file write
- MemWrite_o  out  1  data memory write
- IRWrite_o  out  1  instruction register / OldPC load
- AdrSrc_o  out  1  memory address: 0 = PC, 1 = ALUOut
- ResultSrc_o  out  2  result: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA_o  out  2  A operand: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB_o  out  2  B operand: 00 = rs2, 01 = imm, 10 = const 4
- ImmSrc_o  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUOp_o  out  2  ALU decoder mode: 00 = add, 01 = sub/branch compare, 10 = funct decode
- mem_req_o  out  1  memory access in progress
- illegal_o  out  1  sticky illegal-opcode flag
- state_o  out  4  current state, for debug

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALRADR 11, EXECU 12, TRAP 15.
- Outputs are Moore, decoded from state only; exceptions are ImmSrc_o and the ready qualification below. Unlisted outputs are 0; selects default to 00.
- Reset (async): state = FETCH, illegal_o = 0. While rst_i is high, every strobe is forced to 0 (PCUpdate, Branch, RegWrite, MemWrite, IRWrite, mem_req).
- Per-state outputs:
  - FETCH: AdrSrc 0, IRWrite 1, A 00, B 10, ALUOp 00, ResultSrc 10, PCUpdate 1, mem_req 1.
  - DECODE: A 01, B 01, ALUOp 00 (branch/jal target into ALUOut).
  - MEMADR: A 10, B 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, mem_req 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, MemWrite 1, mem_req 1.
  - EXECR: A 10, B 00, ALUOp 10.
  - EXECI: A 10, B 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BRANCH: A 10, B 00, ALUOp 01, ResultSrc 00, Branch 1.
  - JAL: A 01, B 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
  - JALRADR: A 10, B 01, ALUOp 00.
  - EXECU: B 01, ALUOp 00; A = 11 for lui, 01 for auipc (op_i bit 5 selects).
  - TRAP: all zero.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op_i: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALRADR; 0110111/0010111 -> EXECU; any other opcode is illegal.
  - MEMADR: op bit 5 = 0 -> MEMREAD, 1 -> MEMWRITE.
  - MEMREAD -> MEMWB. MEMWB, MEMWRITE, BRANCH -> FETCH.
  - EXECR, EXECI, EXECU, JAL -> ALUWB. JALRADR -> JAL. ALUWB -> FETCH.
  - Illegal opcode: -> TRAP with illegal_o set if TRAP_ON_ILLEGAL = 1; otherwise -> FETCH with illegal_o pulsed for one cycle.
  - TRAP is absorbing until reset.
- Handshake (MEM_HANDSHAKE = 1):
  - FETCH, MEMREAD and MEMWRITE hold until mem_ready_i = 1.
  - IRWrite_o and PCUpdate_o in FETCH are ANDed with mem_ready_i.
  - MemWrite_o, AdrSrc_o and mem_req_o stay asserted while waiting.
  - ready arriving in the first cycle of a state gives no extra latency.
- Latency (no wait states): lw 5 cycles; sw, R, I, lui, auipc, jal 4; beq 3; jalr 5.
- ImmSrc_o is combinational from op_i in every state: lw/I-type/jalr -> 000, sw -> 001, branch -> 010, jal -> 011, lui/auipc -> 100, others -> 000.
- Reset asserted mid-instruction aborts immediately to FETCH; no partial strobe may follow.

Test Plan:
- Reset, then op 0000011, ready = 1 -> states 0, 1, 2, 3, 4, 0; RegWrite_o high only in state 4 with ResultSrc_o = 01.
- op 0100011, MEM_HANDSHAKE = 1, ready low for 3 cycles in MEMWRITE -> state_o = 5 for 4 cycles, MemWrite_o high throughout, then FETCH.
- op 1100111 -> states 0, 1, 11, 10, 8, 0; JAL state has A = 01, B = 10, PCUpdate_o = 1.
- op 0110111 -> EXECU with ALUSrcA_o = 11, ImmSrc_o = 100; op 0010111 -> ALUSrcA_o = 01.
- op 1111111, TRAP_ON_ILLEGAL = 1 -> state_o = 15, illegal_o = 1, all strobes 0 for 10+ cycles; assert rst_i -> state_o = 0 and illegal_o = 0 asynchronously.
- Handshake FETCH with ready = 0 -> IRWrite_o = 0 and PCUpdate_o = 0 while holding; rst_i pulsed while in MEMREAD -> FETCH, RegWrite_o never asserts.
